// File: rtl/frontend_fetch_ctrl.sv
// frontend_fetch_ctrl: single-outstanding I$ fetch sequencer feeding the instruction queue.
// Optional replay throttling is enabled by defining FETCH_CTRL_REPLAY_THROTTLE_EN.
module frontend_fetch_ctrl #(
  parameter logic [63:0] BOOT_ADDR    = 64'h0000_0000_0001_0000,
  parameter int unsigned FETCH_BYTES  = 8,
  parameter int unsigned REPLAY_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [63:0] redirect_addr_i,
  input  logic        halt_i,
  output logic        req_o,
  output logic [63:0] vaddr_o,
  input  logic        gnt_i,
  input  logic        rsp_valid_i,
  input  logic [63:0] rsp_data_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_data_o,
  output logic [63:0] fetch_addr_o,
  input  logic        predict_taken_i,
  input  logic [63:0] predict_addr_i,
  input  logic        replay_i,
  input  logic [63:0] replay_addr_i,
  input  logic        queue_ready_i
);
  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;
  localparam logic [63:0] BLK  = 64'(FETCH_BYTES);
  logic [2:0]  state_q, state_d;
  logic [63:0] npc_q, npc_d, vaddr_q, seq_addr;
  logic        rsp_fwd, throttle;
  assign req_o         = state_q == FETCH;
  assign vaddr_o       = npc_q;
  assign rsp_fwd       = state_q == WAIT && rsp_valid_i && !flush_i;
  assign fetch_valid_o = rsp_fwd;
  assign fetch_data_o  = rsp_fwd ? rsp_data_i : '0;
  assign fetch_addr_o  = rsp_fwd ? vaddr_q : '0;
  assign seq_addr      = (vaddr_q & ~(BLK - 64'd1)) + BLK;
`ifdef FETCH_CTRL_REPLAY_THROTTLE_EN
  localparam logic [2:0] THROTTLE = 3'd5;
  localparam int CW = $clog2(REPLAY_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(REPLAY_LIMIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i || (state_q == THROTTLE && queue_ready_i)) cnt_d = '0;
    else if (rsp_fwd) cnt_d = !replay_i ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
  end
  assign throttle = cnt_d == LIM;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_ready;
  assign unused_ready = queue_ready_i;
  assign throttle     = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: state_d = gnt_i ? (flush_i ? DRAIN : WAIT) : (!flush_i && halt_i) ? HALT : FETCH;
      WAIT:  state_d = !rsp_valid_i ? (flush_i ? DRAIN : WAIT) :
                       flush_i ? FETCH : halt_i ? HALT :
`ifdef FETCH_CTRL_REPLAY_THROTTLE_EN
                       throttle ? THROTTLE :
`endif
                       FETCH;
      DRAIN: state_d = rsp_valid_i ? FETCH : DRAIN;
      HALT:  state_d = (flush_i || halt_i) ? HALT : FETCH;
`ifdef FETCH_CTRL_REPLAY_THROTTLE_EN
      THROTTLE: state_d = (flush_i || queue_ready_i) ? FETCH : THROTTLE;
`endif
      default: state_d = BOOT;
    endcase
    npc_d = flush_i ? redirect_addr_i :
            !rsp_fwd ? npc_q :
            replay_i ? replay_addr_i :
            predict_taken_i ? predict_addr_i : seq_addr;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= BOOT;
      npc_q   <= BOOT_ADDR;
      vaddr_q <= '0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      if (state_q == FETCH && gnt_i) vaddr_q <= npc_q;
    end
endmodule

// File: tb/tb_frontend_fetch_ctrl.sv
// tb_frontend_fetch_ctrl: directed and randomized checks of frontend_fetch_ctrl against a next-PC model.
module tb_frontend_fetch_ctrl;
  localparam logic [63:0] BOOT = 64'h1_0000;
  localparam int FB = 8;
  localparam int LIMIT = 4;
  logic clk = 0, rst_ni = 0, flush_i = 0, halt_i = 0, gnt_i = 0, rsp_valid_i = 0;
  logic predict_taken_i = 0, replay_i = 0, queue_ready_i = 1;
  logic [63:0] redirect_addr_i = 0, rsp_data_i = 0, predict_addr_i = 0, replay_addr_i = 0;
  logic req_o, fetch_valid_o;
  logic [63:0] vaddr_o, fetch_data_o, fetch_addr_o;
  int errors = 0, checks = 0, rcnt = 0;
  logic [63:0] model_npc;

  frontend_fetch_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .redirect_addr_i(redirect_addr_i),
    .halt_i(halt_i), .req_o(req_o), .vaddr_o(vaddr_o), .gnt_i(gnt_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .fetch_valid_o(fetch_valid_o),
    .fetch_data_o(fetch_data_o), .fetch_addr_o(fetch_addr_o),
    .predict_taken_i(predict_taken_i), .predict_addr_i(predict_addr_i),
    .replay_i(replay_i), .replay_addr_i(replay_addr_i), .queue_ready_i(queue_ready_i));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] next_pc(input logic [63:0] a, input logic pt, input logic [63:0] pa,
                                         input logic rp, input logic [63:0] ra);
    if (rp) return ra;
    if (pt) return pa;
    return a - (a % FB) + FB;
  endfunction

  // One full request/response transaction; returns what the DUT showed, comparisons stay with the caller.
  task automatic fetch_one(input int gd, input int rd, input logic pt, input logic [63:0] pa,
                           input logic rp, input logic [63:0] ra, input logic [63:0] d,
                           output logic rq, output logic [63:0] addr, output logic stable,
                           output logic fv, output logic [63:0] fa, output logic [63:0] fd);
    rq = req_o;
    addr = vaddr_o;
    stable = 1;
    for (int i = 0; i < gd; i++) begin
      tick();
      stable &= req_o && vaddr_o == addr;
    end
    gnt_i = 1;
    tick();
    gnt_i = 0;
    for (int i = 0; i < rd; i++) tick();
    rsp_valid_i = 1; rsp_data_i = d; predict_taken_i = pt; predict_addr_i = pa;
    replay_i = rp; replay_addr_i = ra;
    #1;
    fv = fetch_valid_o; fa = fetch_addr_o; fd = fetch_data_o;
    tick();
    rsp_valid_i = 0; predict_taken_i = 0; replay_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) tick();
    checks += 5;
    if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_o); end
    if (vaddr_o !== BOOT) begin errors++; $display("FAIL reset_vaddr got=%h exp=%h", vaddr_o, BOOT); end
    if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid_o); end
    if (fetch_addr_o !== 64'd0) begin errors++; $display("FAIL reset_faddr got=%h exp=0", fetch_addr_o); end
    if (fetch_data_o !== 64'd0) begin errors++; $display("FAIL reset_fdata got=%h exp=0", fetch_data_o); end
    rst_ni = 1;
    #1;
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL boot_noreq got=%b exp=0", req_o); end
    tick();
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== BOOT) begin errors++; $display("FAIL first_req got=%b/%h exp=1/%h", req_o, vaddr_o, BOOT); end
    model_npc = BOOT;
    rcnt = 0;
  endtask

  // Runs one transaction and compares everything against the model; shared by the scenario tasks below.
  task automatic run_and_check(input string nm, input int gd, input int rd, input logic pt, input logic [63:0] pa,
                               input logic rp, input logic [63:0] ra);
    logic rq, st, fv;
    logic [63:0] a, fa, fd, d;
    d = {$urandom, $urandom};
    fetch_one(gd, rd, pt, pa, rp, ra, d, rq, a, st, fv, fa, fd);
    checks += 4;
    if (rq !== 1'b1 || a !== model_npc) begin errors++; $display("FAIL %s_req got=%b/%h exp=1/%h", nm, rq, a, model_npc); end
    if (st !== 1'b1) begin errors++; $display("FAIL %s_stable got=%b exp=1", nm, st); end
    if (fv !== 1'b1 || fa !== model_npc) begin errors++; $display("FAIL %s_fwd got=%b/%h exp=1/%h", nm, fv, fa, model_npc); end
    if (fd !== d) begin errors++; $display("FAIL %s_data got=%h exp=%h", nm, fd, d); end
    model_npc = next_pc(model_npc, pt, pa, rp, ra);
    rcnt = rp ? (rcnt < LIMIT ? rcnt + 1 : rcnt) : 0;
`ifdef FETCH_CTRL_REPLAY_THROTTLE_EN
    if (rcnt == LIMIT) begin
      checks++;
      if (req_o !== 1'b0) begin errors++; $display("FAIL %s_throttle got=%b exp=0", nm, req_o); end
      if (queue_ready_i) begin tick(); rcnt = 0; end
    end
`endif
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_and_check("seq", 0, 0, 0, 0, 0, 0);
    checks++;
    if (model_npc !== 64'h1_0018 || vaddr_o !== model_npc) begin errors++; $display("FAIL seq_npc got=%h exp=%h", vaddr_o, 64'h1_0018); end
  endtask

  task automatic test_predict();
    run_and_check("pred", 0, 0, 1, 64'h2004, 0, 0);
    checks++;
    if (vaddr_o !== 64'h2004) begin errors++; $display("FAIL pred_target got=%h exp=2004", vaddr_o); end
    run_and_check("pred_seq", 0, 0, 0, 0, 0, 0);
    checks++;
    if (vaddr_o !== 64'h2008) begin errors++; $display("FAIL pred_seq got=%h exp=2008", vaddr_o); end
    run_and_check("wrap_in", 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    run_and_check("wrap", 0, 0, 0, 0, 0, 0);
    checks++;
    if (vaddr_o !== 64'h0) begin errors++; $display("FAIL wrap_npc got=%h exp=0", vaddr_o); end
  endtask

  task automatic test_flush_rsp();
    gnt_i = 1;
    tick();
    gnt_i = 0;
    rsp_valid_i = 1; flush_i = 1; redirect_addr_i = 64'h8000;
    #1;
    checks++;
    if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL flush_rsp_fv got=%b exp=0", fetch_valid_o); end
    tick();
    rsp_valid_i = 0; flush_i = 0;
    model_npc = 64'h8000;
    rcnt = 0;
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== 64'h8000) begin errors++; $display("FAIL flush_rsp_req got=%b/%h exp=1/8000", req_o, vaddr_o); end
  endtask

  task automatic test_flush_wait();
    gnt_i = 1;
    tick();
    gnt_i = 0;
    flush_i = 1; redirect_addr_i = 64'h4000;
    tick();
    flush_i = 0;
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL drain_req got=%b exp=0", req_o); end
    tick();
    rsp_valid_i = 1;
    #1;
    checks++;
    if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL drain_fv got=%b exp=0", fetch_valid_o); end
    tick();
    rsp_valid_i = 0;
    model_npc = 64'h4000;
    rcnt = 0;
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== 64'h4000) begin errors++; $display("FAIL drain_exit got=%b/%h exp=1/4000", req_o, vaddr_o); end
  endtask

  task automatic test_halt();
    halt_i = 1;
    tick();
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL halt_drop got=%b exp=0", req_o); end
    repeat (2) tick();
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL halt_hold got=%b exp=0", req_o); end
    halt_i = 0;
    tick();
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== model_npc) begin errors++; $display("FAIL halt_resume got=%b/%h exp=1/%h", req_o, vaddr_o, model_npc); end
    run_and_check("post_halt", 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_replay_limit();
    run_and_check("pre_rp", 0, 0, 0, 0, 0, 0);
    queue_ready_i = 0;
    for (int i = 0; i < LIMIT; i++) begin
      logic rq, st, fv;
      logic [63:0] a, fa, fd;
      fetch_one(0, 0, 0, 0, 1, 64'h100, 64'h0, rq, a, st, fv, fa, fd);
      checks++;
      if (rq !== 1'b1 || fv !== 1'b1) begin errors++; $display("FAIL rp_txn%0d got=%b/%b exp=1/1", i, rq, fv); end
    end
    model_npc = 64'h100;
`ifdef FETCH_CTRL_REPLAY_THROTTLE_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_o !== 1'b0) begin errors++; $display("FAIL throttle_hold got=%b exp=0", req_o); end
      tick();
    end
    queue_ready_i = 1;
    tick();
`endif
    queue_ready_i = 1;
    rcnt = 0;
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== 64'h100) begin errors++; $display("FAIL rp_resume got=%b/%h exp=1/100", req_o, vaddr_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic pt, rp;
      logic [63:0] pa, ra;
      pt = 1'($urandom_range(0, 1));
      rp = $urandom_range(0, 3) == 0;
      pa = {$urandom, $urandom};
      ra = {32'h0, $urandom};
      run_and_check("rnd", $urandom_range(0, 3), $urandom_range(0, 3), pt, pa, rp, ra);
    end
  endtask

  task automatic test_reset_mid();
    gnt_i = 1;
    tick();
    gnt_i = 0;
    #2 rst_ni = 0;
    #1;
    checks++;
    if (req_o !== 1'b0 || vaddr_o !== BOOT || fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid got=%b/%h/%b exp=0/%h/0", req_o, vaddr_o, fetch_valid_o, BOOT);
    end
    tick();
    rst_ni = 1;
    tick();
    checks++;
    if (req_o !== 1'b1 || vaddr_o !== BOOT) begin errors++; $display("FAIL reset_mid_req got=%b/%h exp=1/%h", req_o, vaddr_o, BOOT); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict();
    test_flush_rsp();
    test_flush_wait();
    test_halt();
    test_replay_limit();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frontend_fetch_ctrl.md
# frontend_fetch_ctrl

Fetch sequencer between the I$ request port and the instruction queue. It owns the fetch PC and issues one outstanding I$ request at a time. Each response is forwarded to the instruction queue. The next fetch address is chosen from flush redirect, queue replay, branch prediction and sequential advance. Fetch can also be halted, and under a macro it throttles after repeated replays to limit replay power.

## Interface
- `BOOT_ADDR`, `64'h0000_0000_0001_0000`: first fetch address after reset.
- `FETCH_BYTES`, `8`: fetch block size in bytes; power of two.
- `REPLAY_LIMIT`, `4`: consecutive replays before throttling; used only with the macro.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: pipeline flush; redirect to `redirect_addr_i`.
- `redirect_addr_i` in 64: flush target.
- `halt_i` in 1: stop fetching (WFI/debug).
- `req_o` out 1: I$ request.
- `vaddr_o` out 64: request address; aligned to `FETCH_BYTES`, low bits preserved for the first block after redirect.
- `gnt_i` in 1: I$ accepted the request.
- `rsp_valid_i` in 1: I$ response valid.
- `rsp_data_i` in 64: I$ response data.
- `fetch_valid_o` out 1: push the response to the instruction queue.
- `fetch_data_o` out 64: response data passthrough.
- `fetch_addr_o` out 64: address of the forwarded block.
- `predict_taken_i` in 1: predictor hit on the forwarded block; valid only while `fetch_valid_o`.
- `predict_addr_i` in 64: predicted target.
- `replay_i` in 1: queue overflow on the forwarded block; valid only while `fetch_valid_o`.
- `replay_addr_i` in 64: replay address.
- `queue_ready_i` in 1: queue has space.

## Operation
- Registers:
  - `npc_q`: next fetch address.
  - `vaddr_q`: address of the in-flight request.
  - `state_q`: FSM state.
  - `replay_cnt_q`: consecutive-replay counter (macro only).
- FSM states:
  - BOOT: reset state, no request; always goes to FETCH next cycle.
  - FETCH: `req_o`=1, `vaddr_o`=`npc_q`, held stable until `gnt_i`. On `gnt_i`: latch `vaddr_q`, go to WAIT.
  - WAIT: wait for `rsp_valid_i`. On response: `fetch_valid_o`=1, `fetch_addr_o`=`vaddr_q`, compute `npc`, go to FETCH. If `halt_i`, go to HALT instead.
  - DRAIN: the in-flight response is killed. On `rsp_valid_i`, discard it (`fetch_valid_o`=0) and go to FETCH.
  - HALT: no request. Leave to FETCH when `halt_i`=0.
  - THROTTLE: macro only; see Configuration.
- Next-PC priority, evaluated on a forwarded response:
  - `replay_i`: `replay_addr_i`.
  - else `predict_taken_i`: `predict_addr_i`.
  - else sequential: `(vaddr_q & ~(FETCH_BYTES-1)) + FETCH_BYTES`, 64-bit wrap, carry dropped.
- `flush_i` overrides everything in any state: `npc_q`←`redirect_addr_i`.
  - From FETCH without grant, or from WAIT: drop the request.
  - Grant pending (FETCH with `gnt_i`, or WAIT without response): go to DRAIN.
  - Response in the same cycle: discard it and go to FETCH.
  - From HALT: stay in HALT.
  - From BOOT: go to FETCH.
- `halt_i` in FETCH without `gnt_i`: withdraw `req_o` and go to HALT. This and flush are the only cases where `req_o` may drop before grant.
- `replay_i`/`predict_taken_i` outside a `fetch_valid_o` cycle are ignored.

## Timing
- Reset values: `req_o`=0, `vaddr_o`=`BOOT_ADDR`, `fetch_valid_o`=0, `fetch_addr_o`=0, `fetch_data_o`=0, `npc_q`=`BOOT_ADDR`, state BOOT.
- First `req_o` is in the 2nd cycle after `rst_ni` deassertion.
- `fetch_valid_o`, `fetch_data_o` and `fetch_addr_o` are combinational from `rsp_valid_i`/state: zero added latency.
- The next `req_o` rises in the cycle after the response, with the new `npc`.
- Minimum spacing: 1 request per 2 cycles when the I$ answers the cycle after grant.
- Reset mid-operation: immediate return to the reset values; any in-flight I$ response must be ignored by the I$ side.

## Configuration
- `FETCH_CTRL_REPLAY_THROTTLE_EN` defined:
  - `replay_cnt_q` ($clog2(`REPLAY_LIMIT`+1) bits) increments on each forwarded response with `replay_i`, saturating.
  - It clears on a forwarded response without replay, and on flush.
  - When it reaches `REPLAY_LIMIT`, the FSM goes to THROTTLE instead of FETCH: no request until `queue_ready_i`=1, then FETCH and counter cleared.
  - Flush exits THROTTLE to FETCH.
- Macro undefined:
  - The counter and THROTTLE state do not exist.
  - `queue_ready_i` is ignored.
  - Replay always refetches immediately.

## Test plan
- Reset release, `gnt_i` tied 1, response 1 cycle after grant: requests at 0x10000, 0x10008, 0x10010. `fetch_addr_o` tracks each request.
- Response with `predict_taken_i`=1, `predict_addr_i`=0x2004: next `vaddr_o`=0x2004, then 0x2008.
- `flush_i` with `redirect_addr_i`=0x8000 in the same cycle as `rsp_valid_i`: `fetch_valid_o`=0, next request 0x8000.
- `flush_i` in WAIT to 0x4000, response two cycles later: response discarded in DRAIN, then request 0x4000.
- `halt_i` while in FETCH with `gnt_i`=0: `req_o` drops next cycle. Release halt: request resumes at the same `npc`.
- Macro on, `REPLAY_LIMIT`=4, four responses with `replay_i`=1, `replay_addr_i`=0x100:
  - Check: `req_o` held 0 while `queue_ready_i`=0; request 0x100 issued the cycle after `queue_ready_i`=1.
  - Macro off: no stall.
